// File: rtl/regfile_write_bank.sv
// Write side of the 32 x 64-bit integer register file.
// Registers 0..30 are enabled flops, and register 31 is the hardwired zero register.
// A per-register "written" bitmap records which registers have been written since reset or clear.
module regfile_write_bank #(
  parameter int NREG  = 32,
  parameter int WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        RegWrite,
  input  logic [4:0]                  WriteReg,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic                        clr_written,
  output logic [NREG-1:0][WIDTH-1:0]  regs,
  output logic [NREG-1:0]             written,
  output logic [NREG-1:0]             dec_en
);

  // Decode tree.
  // Level 1 is a 1:2 split on WriteReg[4].
  // Level 2 is a 1:4 split on WriteReg[3:2], giving 8 groups.
  // Level 3 is a 1:4 split on WriteReg[1:0].
  // This shape matches the read-select tree.
  logic [1:0]      dec_hi;
  logic [7:0]      dec_mid;
  logic [NREG-1:0] dec_full;

  logic [NREG-2:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREG-2:0]            written_q, written_d;

  // First decode level: 1:2 on the top address bit.
  always_comb begin
    dec_hi = '0;
    dec_hi[WriteReg[4]] = RegWrite;
  end

  // Second decode level: each half splits 1:4 on WriteReg[3:2].
  always_comb begin
    dec_mid = '0;
    for (int h = 0; h < 2; h++) begin
      for (int q = 0; q < 4; q++) begin
        dec_mid[h*4+q] = dec_hi[h] & (WriteReg[3:2] == 2'(q));
      end
    end
  end

  // Leaf decode level: each group of four splits 1:4 on WriteReg[1:0].
  always_comb begin
    dec_full = '0;
    for (int g = 0; g < 8; g++) begin
      for (int l = 0; l < 4; l++) begin
        dec_full[g*4+l] = dec_mid[g] & (WriteReg[1:0] == 2'(l));
      end
    end
  end

  // The enable for register 31 is forced low, so a write to 31 has no side effects.
  always_comb begin
    dec_en = {1'b0, dec_full[NREG-2:0]};
  end

  // Next-state logic for storage and the bitmap.
  // In the bitmap, setting a bit takes priority over clr_written.
  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    for (int i = 0; i < NREG-1; i++) begin
      if (dec_en[i]) begin
        regs_d[i] = WriteData;
      end
      written_d[i] = dec_en[i] | (written_q[i] & ~clr_written);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q    <= '0;
      written_q <= '0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end

  // Outputs come straight from the flops.
  // Slot 31 is the constant zero register.
  always_comb begin
    regs              = '0;
    regs[NREG-2:0]    = regs_q;
    written           = {1'b0, written_q};
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Randomised and directed bench for regfile_write_bank, checked against an array model.
module tb_regfile_write_bank;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              RegWrite = 1'b0;
  logic [4:0]        WriteReg = '0;
  logic [63:0]       WriteData = '0;
  logic              clr_written = 1'b0;
  logic [31:0][63:0] regs;
  logic [31:0]       written;
  logic [31:0]       dec_en;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [31:0] m_written = '0;

  regfile_write_bank #(.NREG(32), .WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .clr_written(clr_written),
    .regs(regs), .written(written), .dec_en(dec_en)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  end

  // Reference model: array registers, a bit-vector bitmap, and register 31 never changes.
  always @(posedge clk) begin
    if (reset_n) begin
      if (clr_written) m_written = '0;
      if (RegWrite && WriteReg != 5'd31) begin
        m_regs[WriteReg]     = WriteData;
        m_written[WriteReg]  = 1'b1;
      end
    end
  end

  always @(negedge reset_n) begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_written = '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge compares all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] exp_dec;
    exp_dec = (RegWrite && WriteReg != 5'd31) ? (32'd1 << WriteReg) : 32'd0;
    check("cmp_dec_en", 64'(dec_en), 64'(exp_dec));
    check("cmp_written", 64'(written), 64'(m_written));
    for (int i = 0; i < 32; i++) begin
      if (regs[i] !== m_regs[i]) check($sformatf("cmp_regs[%0d]", i), regs[i], m_regs[i]);
      else checks++;
    end
  end

  // Inputs change 2 time units after a rising edge and are captured at the next rising edge.
  task automatic drive(input logic we, input logic [4:0] a, input logic [63:0] d, input logic clr);
    @(posedge clk);
    #2;
    RegWrite = we; WriteReg = a; WriteData = d; clr_written = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    repeat (2) @(posedge clk);
    #1;
    check("reset_written", 64'(written), 64'd0);
    check("reset_regs0", regs[0], 64'd0);
    #1 reset_n = 1'b1;

    // Sweep over all register addresses, including 31.
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 64'h1000 + 64'(i), 1'b0);
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1;
    for (int i = 0; i < 31; i++) check($sformatf("sweep_reg%0d", i), regs[i], 64'h1000 + 64'(i));
    check("sweep_reg31", regs[31], 64'd0);
    check("sweep_written", 64'(written), 64'h7FFF_FFFF);

    // Enable off.
    drive(1'b0, 5'd5, 64'hDEAD, 1'b0);
    #1 check("enoff_dec_en", 64'(dec_en), 64'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1 check("enoff_reg5", regs[5], 64'h1005);

    // Read-during-write.
    drive(1'b1, 5'd3, 64'd17, 1'b0);
    drive(1'b1, 5'd3, 64'd25, 1'b0);
    #1 check("rdw_before", regs[3], 64'd17);
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1 check("rdw_after", regs[3], 64'd25);
    check("rdw_neighbour", regs[4], 64'h1004);

    // Bitmap clear while register 13 is being written.
    drive(1'b1, 5'd12, 64'h12, 1'b0);
    drive(1'b1, 5'd13, 64'h13, 1'b1);
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1 check("bitmap_written", 64'(written), 64'h0000_2000);

    // Write to the zero register.
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #1 check("zero_dec_en", 64'(dec_en), 64'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1 check("zero_reg31", regs[31], 64'd0);
    check("zero_written", 64'(written), 64'h0000_2000);

    // Decoder walk.
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), 64'(i) * 64'h0101, 1'b0);
      #1 check($sformatf("dec_walk%0d", i), 64'(dec_en), 64'(32'd1 << i));
    end

    // Asynchronous reset in mid-cycle while a write is pending.
    drive(1'b1, 5'd7, 64'hABC, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("async_reg7", regs[7], 64'd0);
    check("async_reg30", regs[30], 64'd0);
    check("async_written", 64'(written), 64'd0);
    @(posedge clk);
    #1 check("rst_ignores_write", regs[7], 64'd0);
    #1 reset_n = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    #1 check("post_rst_write7", regs[7], 64'hABC);

    // Random traffic with occasional clears and reset pulses.
    for (int n = 0; n < 2000; n++) begin
      d = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), d,
            ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
      end
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
